// File: rtl/dda_column_buffer.sv
// dda_column_buffer
//   Consumer end of the DDA output stream. Each 38-bit ray beat is stored in a
//   ping-pong column table indexed by hcount_ray. The DDA fills the write bank
//   while the wall/texture renderer reads the display bank by column. Banks
//   swap only once a full frame (tlast) has landed and the renderer pulses
//   swap_req_in at its own frame boundary.
//
// Ports
//   pixel_clk_in, rst_n_in    : clock, asynchronous active-low reset
//   dda_out_tvalid/tdata/tlast: upstream ray beats
//                               tdata = {hcount[37:29], lineHeight[28:21],
//                                        wallType[20], mapData[19:16], wallX[15:0]}
//   dda_out_tready            : high while filling
//   swap_req_in               : renderer end-of-frame pulse
//   rd_req_in, rd_hcount_in   : column read request (2-cycle latency)
//   rd_valid_out, rd_*_out    : read result; zeros for unwritten/out-of-range
//   frame_ready_out           : complete frame waiting for a swap
//
// Optional build macro
//   DDA_COLBUF_STATS_EN adds frame_count_out, drop_count_out, missing_cols_out.

module dda_column_buffer #(
  parameter int unsigned SCREEN_WIDTH  = 320,
  parameter int unsigned SCREEN_HEIGHT = 180
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        dda_out_tvalid,
  input  logic [37:0] dda_out_tdata,
  input  logic        dda_out_tlast,
  output logic        dda_out_tready,
  input  logic        swap_req_in,
  input  logic        rd_req_in,
  input  logic [8:0]  rd_hcount_in,
  output logic        rd_valid_out,
  output logic [7:0]  rd_lineHeight_out,
  output logic        rd_wallType_out,
  output logic [3:0]  rd_mapData_out,
  output logic [15:0] rd_wallX_out,
`ifdef DDA_COLBUF_STATS_EN
  output logic [15:0] frame_count_out,
  output logic [15:0] drop_count_out,
  output logic [8:0]  missing_cols_out,
`endif
  output logic        frame_ready_out
);

  localparam int unsigned HC_W  = 9;
  localparam int unsigned LH_W  = 8;
  localparam int unsigned IDX_W = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;

  localparam logic [HC_W:0] LP_COLS   = (HC_W+1)'(SCREEN_WIDTH);
  localparam logic [LH_W:0] LP_MAX_LH = (LH_W+1)'(SCREEN_HEIGHT);

  typedef enum logic {
    ST_FILL      = 1'b0,
    ST_WAIT_SWAP = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0]  line_height;
    logic        wall_type;
    logic [3:0]  map_data;
    logic [15:0] wall_x;
  } col_entry_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_tready_nxt;
  logic       w_frame_ready_nxt;
  logic       r_tready;
  logic       r_frame_ready;
  logic       r_wr_bank;
  logic       w_disp_bank;

  logic [HC_W-1:0]  w_hcount;
  logic [IDX_W-1:0] w_wr_idx;
  col_entry_t       w_beat;
  logic             w_accept;
  logic             w_in_range;
  logic             w_wr_en;
  logic             w_drop;
  logic             w_swap;

  logic [SCREEN_WIDTH-1:0] r_valid [2];
  col_entry_t              r_mem   [2][SCREEN_WIDTH];

  logic             w_rd_in_range;
  logic [IDX_W-1:0] w_rd_idx;
  logic             r_s1_req;
  logic             r_s1_hit;
  logic             r_s1_bank;
  logic [IDX_W-1:0] r_s1_idx;
  logic             r_rd_valid;
  col_entry_t       r_rd_entry;

  // Beat decode with line height clamped to the display height.
  assign w_hcount   = dda_out_tdata[37:29];
  assign w_wr_idx   = IDX_W'(w_hcount);
  assign w_in_range = {1'b0, w_hcount} < LP_COLS;
  assign w_accept   = dda_out_tvalid && r_tready;
  assign w_wr_en    = w_accept && w_in_range;
  assign w_drop     = w_accept && !w_in_range;
  assign w_swap     = (r_state == ST_WAIT_SWAP) && swap_req_in;
  assign w_disp_bank = ~r_wr_bank;

  always_comb begin
    w_beat.line_height = dda_out_tdata[28:21];
    if ({1'b0, dda_out_tdata[28:21]} > LP_MAX_LH) begin
      w_beat.line_height = LP_MAX_LH[LH_W-1:0];
    end
    w_beat.wall_type = dda_out_tdata[20];
    w_beat.map_data  = dda_out_tdata[19:16];
    w_beat.wall_x    = dda_out_tdata[15:0];
  end

  // Next state; tready/frame_ready are registered from the next state.
  always_comb begin
    w_state_nxt       = r_state;
    w_tready_nxt      = 1'b0;
    w_frame_ready_nxt = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        if (w_accept && dda_out_tlast) begin
          w_state_nxt = ST_WAIT_SWAP;
        end
      end
      ST_WAIT_SWAP: begin
        if (swap_req_in) begin
          w_state_nxt = ST_FILL;
        end
      end
    endcase
    w_tready_nxt      = (w_state_nxt == ST_FILL);
    w_frame_ready_nxt = (w_state_nxt == ST_WAIT_SWAP);
  end

  // State, handshake outputs and bank pointer.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= ST_FILL;
      r_tready      <= 1'b0;
      r_frame_ready <= 1'b0;
      r_wr_bank     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tready      <= w_tready_nxt;
      r_frame_ready <= w_frame_ready_nxt;
      if (w_swap) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Valid bitmaps; the bank about to become the write bank starts empty.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid[0] <= '0;
      r_valid[1] <= '0;
    end else if (w_swap) begin
      r_valid[~r_wr_bank] <= '0;
    end else if (w_wr_en) begin
      r_valid[r_wr_bank][w_wr_idx] <= 1'b1;
    end
  end

  // Column storage; stale contents are masked by the bitmaps.
  always_ff @(posedge pixel_clk_in) begin
    if (w_wr_en) begin
      r_mem[r_wr_bank][w_wr_idx] <= w_beat;
    end
  end

  assign w_rd_in_range = {1'b0, rd_hcount_in} < LP_COLS;
  assign w_rd_idx      = w_rd_in_range ? IDX_W'(rd_hcount_in) : '0;

  // Read stage 1: bank and hit are frozen at request time so a swap in
  // flight cannot redirect an outstanding read.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_s1_req  <= 1'b0;
      r_s1_hit  <= 1'b0;
      r_s1_bank <= 1'b0;
      r_s1_idx  <= '0;
    end else begin
      r_s1_req <= rd_req_in;
      if (rd_req_in) begin
        r_s1_hit  <= w_rd_in_range && r_valid[w_disp_bank][w_rd_idx];
        r_s1_bank <= w_disp_bank;
        r_s1_idx  <= w_rd_idx;
      end
    end
  end

  // Read stage 2: data holds between matured requests.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rd_valid <= 1'b0;
      r_rd_entry <= '0;
    end else begin
      r_rd_valid <= r_s1_req;
      if (r_s1_req) begin
        r_rd_entry <= r_s1_hit ? r_mem[r_s1_bank][r_s1_idx] : '0;
      end
    end
  end

  assign dda_out_tready    = r_tready;
  assign frame_ready_out   = r_frame_ready;
  assign rd_valid_out      = r_rd_valid;
  assign rd_lineHeight_out = r_rd_entry.line_height;
  assign rd_wallType_out   = r_rd_entry.wall_type;
  assign rd_mapData_out    = r_rd_entry.map_data;
  assign rd_wallX_out      = r_rd_entry.wall_x;

`ifdef DDA_COLBUF_STATS_EN
  logic [15:0]             r_frame_count;
  logic [15:0]             r_drop_count;
  logic [HC_W-1:0]         r_missing;
  logic [SCREEN_WIDTH-1:0] w_bitmap_after;
  logic                    w_enter_wait;

  // Bitmap including the beat landing this cycle (the tlast beat counts).
  assign w_bitmap_after = r_valid[r_wr_bank] |
                          (w_wr_en ? (SCREEN_WIDTH'(1) << w_wr_idx) : '0);
  assign w_enter_wait   = (r_state == ST_FILL) && (w_state_nxt == ST_WAIT_SWAP);

  // Frame/drop/missing-column statistics.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
      r_missing     <= '0;
    end else begin
      if (w_swap) begin
        r_frame_count <= r_frame_count + 16'd1;
        r_drop_count  <= '0;
      end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      if (w_enter_wait) begin
        r_missing <= HC_W'(SCREEN_WIDTH) - HC_W'($countones(w_bitmap_after));
      end
    end
  end

  assign frame_count_out  = r_frame_count;
  assign drop_count_out   = r_drop_count;
  assign missing_cols_out = r_missing;
`endif

endmodule

// File: tb/tb_dda_column_buffer.sv
// Testbench for dda_column_buffer: drives DDA frames, swaps and column reads;
// read results are predicted from a bank/bitmap model into a scoreboard queue
// and checked for data and exact 2-cycle latency as they return.

module tb_dda_column_buffer;

  localparam int W = 320;
  localparam int H = 180;

  logic        clk;
  logic        rst_n;
  logic        dda_out_tvalid;
  logic [37:0] dda_out_tdata;
  logic        dda_out_tlast;
  logic        dda_out_tready;
  logic        swap_req;
  logic        rd_req;
  logic [8:0]  rd_hcount;
  logic        rd_valid;
  logic [7:0]  rd_lh;
  logic        rd_wt;
  logic [3:0]  rd_md;
  logic [15:0] rd_wx;
  logic        frame_ready;
`ifdef DDA_COLBUF_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] drop_count;
  logic [8:0]  missing_cols;
`endif

  dda_column_buffer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
    .pixel_clk_in      (clk),
    .rst_n_in          (rst_n),
    .dda_out_tvalid    (dda_out_tvalid),
    .dda_out_tdata     (dda_out_tdata),
    .dda_out_tlast     (dda_out_tlast),
    .dda_out_tready    (dda_out_tready),
    .swap_req_in       (swap_req),
    .rd_req_in         (rd_req),
    .rd_hcount_in      (rd_hcount),
    .rd_valid_out      (rd_valid),
    .rd_lineHeight_out (rd_lh),
    .rd_wallType_out   (rd_wt),
    .rd_mapData_out    (rd_md),
    .rd_wallX_out      (rd_wx),
`ifdef DDA_COLBUF_STATS_EN
    .frame_count_out   (frame_count),
    .drop_count_out    (drop_count),
    .missing_cols_out  (missing_cols),
`endif
    .frame_ready_out   (frame_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [28:0] data; int due; } exp_t;
  exp_t sbq[$];

  // Reference model of the two banks.
  logic [28:0] m_mem [2][W];
  bit          m_vld [2][W];
  int          m_wr;
  bit          m_wait;
  int          m_frames, m_drops, m_missing;

  function automatic logic [28:0] gen(input int fid, input int h);
    logic [7:0] lh;
    if (fid == 0) lh = 8'(h % 181);
    else          lh = 8'((h * 7 + fid * 13) % 256);
    return {lh, 1'((h + fid) & 1), 4'((h ^ fid) & 15), 16'(h * 97 + fid * 1000)};
  endfunction

  function automatic logic [28:0] clamp(input logic [28:0] e);
    logic [28:0] r;
    r = e;
    if (int'(e[28:21]) > H) r[28:21] = 8'(H);
    return r;
  endfunction

  function automatic logic [28:0] mdl_rd(input int h);
    int d;
    d = 1 - m_wr;
    if (h >= W) return '0;
    return m_vld[d][h] ? m_mem[d][h] : '0;
  endfunction

  task automatic mdl_reset();
    for (int b = 0; b < 2; b++) for (int i = 0; i < W; i++) m_vld[b][i] = 0;
    m_wr = 0; m_wait = 0; m_frames = 0; m_drops = 0; m_missing = 0;
  endtask

  task automatic mdl_accept(input int h, input logic [28:0] raw, input bit last);
    int cnt;
    if (h < W) begin
      m_mem[m_wr][h] = clamp(raw);
      m_vld[m_wr][h] = 1;
    end else if (m_drops < 65535) begin
      m_drops++;
    end
    if (last) begin
      m_wait = 1;
      cnt = 0;
      for (int i = 0; i < W; i++) if (m_vld[m_wr][i]) cnt++;
      m_missing = W - cnt;
    end
  endtask

  task automatic mdl_swap();
    if (m_wait) begin
      m_wr = 1 - m_wr;
      for (int i = 0; i < W; i++) m_vld[m_wr][i] = 0;
      m_wait = 0;
      m_frames = (m_frames + 1) % 65536;
      m_drops = 0;
    end
  endtask

  // Read-result scoreboard: data and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [28:0] got;
    got = {rd_lh, rd_wt, rd_md, rd_wx};
    if (rd_valid === 1'b1) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: cycle %0d rd_valid=1 data=%h, required no read outstanding", cyc, got);
      end else begin
        e = sbq.pop_front();
        if (got !== e.data || cyc != e.due) begin
          miscompares++;
          $display("FAIL rd_data: cycle %0d data=%h, required data=%h at cycle %0d", cyc, got, e.data, e.due);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL rd_late: cycle %0d rd_valid=%b, required 1 with data=%h", cyc, rd_valid, sbq[0].data);
      void'(sbq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int h, input logic [28:0] raw, input bit last);
    bit done, rdy;
    done = 0;
    dda_out_tvalid = 1'b1;
    dda_out_tdata  = {9'(h), raw};
    dda_out_tlast  = last;
    for (int n = 0; n < 50 && !done; n++) begin
      rdy = dda_out_tready;
      step();
      if (rdy) begin
        mdl_accept(h, raw, last);
        done = 1;
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL beat_accept: hcount %0d tready=%b, required 1 within 50 cycles", h, dda_out_tready);
    end
    dda_out_tlast = 1'b0;
  endtask

  task automatic send_range(input int fid, input int lo, input int hi, input int skip,
                            input int drop_after, input bit last);
    for (int h = lo; h <= hi; h++) begin
      if (h != skip) send_beat(h, gen(fid, h), last && (h == hi));
      if (h == drop_after) send_beat(330, gen(fid, 330), 1'b0);
    end
    dda_out_tvalid = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    mdl_swap();
  endtask

  task automatic rd_issue(input int h);
    rd_req = 1'b1;
    rd_hcount = 9'(h);
    sbq.push_back('{mdl_rd(h), cyc + 2});
    step();
    rd_req = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 10 && sbq.size() > 0; n++) step();
    if (sbq.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL rd_drain: %0d reads outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({dda_out_tready, frame_ready, rd_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: tready/frame_ready/rd_valid=%b, required 000", {dda_out_tready, frame_ready, rd_valid});
    end
    vectors++;
    if ({rd_lh, rd_wt, rd_md, rd_wx} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_data: rd data=%h, required 0", {rd_lh, rd_wt, rd_md, rd_wx});
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    vectors++;
    if (dda_out_tready !== 1'b1 || frame_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: tready=%b frame_ready=%b, required 1 0", dda_out_tready, frame_ready);
    end
    // Display bank is empty and 400 is out of range: both read as zero.
    rd_issue(0);
    rd_issue(400);
    drain();
  endtask

  task automatic test_fill_read();
    send_range(0, 0, W - 1, -1, -1, 1'b1);
    vectors++;
    if (frame_ready !== 1'b1 || dda_out_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_wait: frame_ready=%b tready=%b, required 1 0", frame_ready, dda_out_tready);
    end
`ifdef DDA_COLBUF_STATS_EN
    vectors++;
    if (missing_cols !== 9'(m_missing)) begin
      miscompares++;
      $display("FAIL stats_missing_full: %0d, required %0d", missing_cols, m_missing);
    end
`endif
    do_swap();
    rd_issue(0);
    rd_issue(100);
    rd_issue(319);
    drain();
  endtask

  task automatic test_drop_missing();
    send_range(1, 0, W - 1, 5, 150, 1'b1);
`ifdef DDA_COLBUF_STATS_EN
    vectors++;
    if (drop_count !== 16'(m_drops) || missing_cols !== 9'(m_missing) || frame_count !== 16'(m_frames)) begin
      miscompares++;
      $display("FAIL stats_drop: drop=%0d missing=%0d frames=%0d, required %0d %0d %0d",
               drop_count, missing_cols, frame_count, m_drops, m_missing, m_frames);
    end
`endif
  endtask

  task automatic test_backpressure();
    bit rdy;
    dda_out_tvalid = 1'b1;
    dda_out_tdata  = {9'd0, gen(2, 0)};
    dda_out_tlast  = 1'b0;
    for (int n = 0; n < 6; n++) begin
      vectors++;
      if (dda_out_tready !== 1'b0 || frame_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_wait: cycle %0d tready=%b frame_ready=%b, required 0 1", n, dda_out_tready, frame_ready);
      end
      step();
    end
    do_swap();
    vectors++;
    if (dda_out_tready !== 1'b1 || frame_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL post_swap: tready=%b frame_ready=%b, required 1 0", dda_out_tready, frame_ready);
    end
    rdy = dda_out_tready;
    step();
    dda_out_tvalid = 1'b0;
    if (rdy) mdl_accept(0, gen(2, 0), 1'b0);
`ifdef DDA_COLBUF_STATS_EN
    vectors++;
    if (drop_count !== 16'(m_drops) || frame_count !== 16'(m_frames) || missing_cols !== 9'(m_missing)) begin
      miscompares++;
      $display("FAIL stats_swap: drop=%0d frames=%0d missing=%0d, required %0d %0d %0d",
               drop_count, frame_count, missing_cols, m_drops, m_frames, m_missing);
    end
`endif
    // Missing col 5, clamped col 30, dropped 330, neighbours.
    rd_issue(5);
    rd_issue(6);
    rd_issue(30);
    rd_issue(330);
    rd_issue(4);
    drain();
  endtask

  task automatic test_swap_ignore();
    bit rdy;
    send_range(2, 1, 100, -1, -1, 1'b0);
    do_swap();
    vectors++;
    if (frame_ready !== 1'b0 || dda_out_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL swap_in_fill: frame_ready=%b tready=%b, required 0 1", frame_ready, dda_out_tready);
    end
    rd_issue(50);
    drain();
    send_range(2, 101, W - 2, -1, -1, 1'b0);
    // Final beat accepted in the same cycle as a swap request.
    dda_out_tvalid = 1'b1;
    dda_out_tdata  = {9'(W - 1), gen(2, W - 1)};
    dda_out_tlast  = 1'b1;
    swap_req       = 1'b1;
    rdy = dda_out_tready;
    step();
    swap_req = 1'b0; dda_out_tlast = 1'b0; dda_out_tvalid = 1'b0;
    vectors++;
    if (rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL tlast_accept: tready=%b, required 1", rdy);
    end else begin
      mdl_swap();
      mdl_accept(W - 1, gen(2, W - 1), 1'b1);
    end
    repeat (3) step();
    vectors++;
    if (frame_ready !== 1'b1 || dda_out_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL tlast_swap_same: frame_ready=%b tready=%b, required 1 0", frame_ready, dda_out_tready);
    end
    rd_issue(50);
    drain();
    do_swap();
    rd_issue(50);
    rd_issue(0);
    rd_issue(319);
    drain();
  endtask

  task automatic test_back_to_back();
    send_range(3, 0, W - 1, -1, -1, 1'b1);
    rd_req = 1'b1;
    rd_hcount = 9'd10;
    sbq.push_back('{mdl_rd(10), cyc + 2});
    step();
    rd_hcount = 9'd11;
    sbq.push_back('{mdl_rd(11), cyc + 2});
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    mdl_swap();
    rd_hcount = 9'd12;
    sbq.push_back('{mdl_rd(12), cyc + 2});
    step();
    rd_req = 1'b0;
    drain();
  endtask

  task automatic test_reset_midframe();
    send_range(4, 0, 149, -1, -1, 1'b0);
    rd_req = 1'b1;
    rd_hcount = 9'd3;
    step();
    rd_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({dda_out_tready, frame_ready, rd_valid} !== 3'b000 || {rd_lh, rd_wt, rd_md, rd_wx} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_async: ctrl=%b data=%h, required 000 and 0",
               {dda_out_tready, frame_ready, rd_valid}, {rd_lh, rd_wt, rd_md, rd_wx});
    end
`ifdef DDA_COLBUF_STATS_EN
    vectors++;
    if ({frame_count, drop_count, missing_cols} !== 41'd0) begin
      miscompares++;
      $display("FAIL reset_stats: %0d %0d %0d, required 0 0 0", frame_count, drop_count, missing_cols);
    end
`endif
    mdl_reset();
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    step();
    vectors++;
    if (dda_out_tready !== 1'b1 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_restart: tready=%b rd_valid=%b, required 1 0", dda_out_tready, rd_valid);
    end
    send_range(5, 0, W - 1, -1, -1, 1'b1);
    vectors++;
    if (frame_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL refill_ready: frame_ready=%b, required 1", frame_ready);
    end
    do_swap();
    rd_issue(0);
    rd_issue(149);
    rd_issue(150);
    rd_issue(319);
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    dda_out_tvalid = 1'b0; dda_out_tdata = '0; dda_out_tlast = 1'b0;
    swap_req = 1'b0; rd_req = 1'b0; rd_hcount = '0;
    mdl_reset();
    test_reset();
    test_fill_read();
    test_drop_missing();
    test_backpressure();
    test_swap_ignore();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
